div_arbiter: RTL and testbench
==============================

# div_arbiter

Controller and two-port arbiter for the shared 32-bit sequential unsigned divider, which computes dividend/divisor as a 64-bit {remainder, quotient} over 32 iterations. It accepts division requests from two requesters using valid/ready handshakes and grants them round-robin. It sequences the divider's start/ready protocol and returns a tagged, registered result on a single response channel. It sits between the two issuing units and the one divider instance.

## Interface
Parameters:
- ZERO_QUOT, 32'hFFFF_FFFF: quotient reported for a zero divisor when the zero-bypass feature is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_dividend  in  32  requester 0 dividend.
- req0_divisor  in  32  requester 0 divisor.
- req1_valid, req1_ready, req1_dividend, req1_divisor: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that owns the result.
- resp_quot  out  32  quotient.
- resp_rem  out  32  remainder.
- resp_dz  out  1  divisor was zero.
- div_start  out  1  one-cycle load pulse to the divider.
- div_a  out  32  divisor to the divider.
- div_b  out  32  dividend to the divider.
- div_rem_quot  in  64  divider result: [63:32] remainder, [31:0] quotient.
- div_ready  in  1  divider done.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - reqN_ready is combinational: it is 1 only for the granted requester, and only while that requester's valid is high.
  - Arbitration:
    - Only one requester valid: that requester is granted.
    - Both valid: the requester not granted last time is granted.
    - After reset, requester 0 has priority.
  - On acceptance: capture dividend, divisor and id into operand registers, and update the last-grant pointer.
  - Next state is LAUNCH, or RESP via zero bypass (see Configuration).
- **LAUNCH**
  - div_start=1 for exactly this cycle.
  - div_a and div_b are driven from the operand registers and held constant through WAIT.
  - Next state is WAIT.
- **WAIT**
  - Hold until div_ready=1.
  - On that cycle, register div_rem_quot[31:0] into resp_quot and [63:32] into resp_rem; set resp_dz=0.
  - Next state is RESP.
- **RESP**
  - resp_valid=1. resp_* are stable until resp_ready=1.
  - On handshake, next state is IDLE.
- No request is accepted outside IDLE; both reqN_ready are 0 in LAUNCH, WAIT and RESP.
- Widths: operands and results are unsigned 32-bit. No sign handling and no truncation.

## Timing
- Reset values while rst_n=0 and on the cycle after:
  - req0_ready=0, req1_ready=0, div_start=0, resp_valid=0.
  - resp_id=0, resp_quot=0, resp_rem=0, resp_dz=0, div_a=0, div_b=0.
  - Last-grant pointer set to 1, which makes requester 0 win first.
- Normal path, with acceptance at cycle T:
  - LAUNCH at T+1.
  - The divider counts from T+2; div_ready rises at T+34.
  - Result captured at T+34; resp_valid=1 from T+35.
  - Minimum occupancy is 36 cycles per operation.
- Back-to-back: a handshake at cycle R means the next acceptance is at R+1 at the earliest. There is no same-cycle turnaround.
- resp_ready may already be high when resp_valid rises; the handshake then completes in that first RESP cycle.
- WAIT acts only on div_ready. The divider clears its done flag on the edge that samples div_start, so a stale ready cannot be taken.
- Reset mid-operation:
  - The FSM returns to IDLE and the in-flight result is discarded.
  - The divider may keep running; the next div_start reloads it, because start has priority inside the divider.

## Configuration
- DIV_ARB_ZERO_BYPASS_EN defined:
  - An accepted request with divisor==0 skips the divider and goes IDLE→RESP.
  - Result: resp_quot=ZERO_QUOT, resp_rem=dividend, resp_dz=1.
  - resp_valid=1 at T+1. div_start is never asserted for that request.
- Not defined:
  - Zero divisors take the normal divider path with normal latency.
  - resp_dz is tied to 0.

## Test plan
- Requester 0 sends 100/7 at T, resp_ready held 1:
  - resp_valid at T+35 with quot=14, rem=2, id=0, dz=0.
  - div_start is high at T+1 only.
- Both requesters valid every cycle, resp_ready=1:
  - Grants alternate 0,1,0,1.
  - resp_id sequence is 0,1,0,1.
  - Never two acceptances within 36 cycles.
- Requester 1 sends 32'hFFFF_FFFF/1:
  - quot=32'hFFFF_FFFF, rem=0.
  - With resp_ready=0 for 10 cycles, resp_* are stable and both reqN_ready stay 0.
- Zero bypass, 55/0 with the macro defined:
  - resp_valid at T+1 with quot=32'hFFFF_FFFF, rem=55, dz=1.
  - No div_start.
  - Without the macro: resp_valid at T+35 and dz=0.
- rst_n=0 asserted at T+10 of an operation:
  - Next cycle all outputs are at their reset values and the FSM is in IDLE.
  - A new request 9/3 then returns quot=3, rem=0 with id=0 priority restored.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: two-port round-robin front end and start/ready sequencer for the shared 32-cycle divider.
// Optional `define DIV_ARB_ZERO_BYPASS_EN answers zero-divisor requests directly, without the divider.
module div_arbiter #(
  parameter logic [31:0] ZERO_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dividend,
  input  logic [31:0] req0_divisor,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dividend,
  input  logic [31:0] req1_divisor,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_quot,
  output logic [31:0] resp_rem,
  output logic        resp_dz,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_rem_quot,
  input  logic        div_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        grant;
  logic        accept;
  logic [31:0] sel_dividend, sel_divisor;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic        dz_q, dz_d;
`else
  logic        unused_zero_quot;
  assign unused_zero_quot = ^ZERO_QUOT;
`endif

  // With both requesting, the one not granted last wins; last_q resets to 1 so requester 0 goes first.
  assign grant        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign sel_dividend = grant ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant ? req1_divisor  : req0_divisor;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    dz_d       = dz_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so nothing appears accepted while reset is held.
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) begin
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          id_d       = grant;
          last_d     = grant;
          state_d    = S_LAUNCH;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (sel_divisor == 32'd0) begin
            quot_d  = ZERO_QUOT;
            rem_d   = sel_dividend;
            dz_d    = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_LAUNCH: begin
        div_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // The divider clears done on the start edge, so div_ready here always belongs to this operation.
        if (div_ready) begin
          quot_d  = div_rem_quot[31:0];
          rem_d   = div_rem_quot[63:32];
`ifdef DIV_ARB_ZERO_BYPASS_EN
          dz_d    = 1'b0;
`endif
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it only takes effect on a rising edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

`ifdef DIV_ARB_ZERO_BYPASS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end
  assign resp_dz = dz_q;
`else
  assign resp_dz = 1'b0;
`endif

  assign resp_id   = id_q;
  assign resp_quot = quot_q;
  assign resp_rem  = rem_q;
  assign div_a     = divisor_q;
  assign div_b     = dividend_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: table-driven directed bench for div_arbiter with a behavioural 32-iteration divider model.
// Expectations follow DIV_ARB_ZERO_BYPASS_EN when it is defined for the build.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_dividend = '0, req0_divisor = '0;
  logic [31:0] req1_dividend = '0, req1_divisor = '0;
  logic        resp_valid, resp_id, resp_dz;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_quot, resp_rem;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [63:0] div_rem_quot = '0;
  logic        div_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = -1;
  int acc_cyc[$];
  bit acc_id[$];

  div_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dz(resp_dz),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_rem_quot(div_rem_quot), .div_ready(div_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: load on start, done flag rises after 32 further edges and stays until the next start.
  function automatic logic [63:0] div_model(input logic [31:0] dividend, input logic [31:0] divisor);
    if (divisor == 32'd0) return {dividend, 32'hFFFF_FFFF};
    return {dividend % divisor, dividend / divisor};
  endfunction

  logic [5:0]  dcnt = '0;
  logic [31:0] d_dividend = '0, d_divisor = '0;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt       <= 6'd32;
      div_ready  <= 1'b0;
      d_divisor  <= div_a;
      d_dividend <= div_b;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 6'd1;
      if (dcnt == 6'd1) begin
        div_ready    <= 1'b1;
        div_rem_quot <= div_model(d_dividend, d_divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (div_start) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (req0_valid && req0_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
    if (req1_valid && req1_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_accept(input bit id, output int t, output bit got);
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1'b1; t = cyc; end
    end
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0_ready"}, req0_ready, 0);
    check({tag, " req1_ready"}, req1_ready, 0);
    check({tag, " div_start"},  div_start, 0);
    check({tag, " resp_valid"}, resp_valid, 0);
    check({tag, " resp_id"},    resp_id, 0);
    check({tag, " resp_quot"},  resp_quot, 0);
    check({tag, " resp_rem"},   resp_rem, 0);
    check({tag, " resp_dz"},    resp_dz, 0);
    check({tag, " div_a"},      div_a, 0);
    check({tag, " div_b"},      div_b, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          id;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    int          lat;
    bit          dz;
    int          starts;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int t, s0;
    bit got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    if (v.id) begin
      req1_valid = 1'b1; req1_dividend = v.dividend; req1_divisor = v.divisor;
    end else begin
      req0_valid = 1'b1; req0_dividend = v.dividend; req0_divisor = v.divisor;
    end
    wait_accept(v.id, t, got);
    check({tag, " accepted"}, got, 1);
    s0 = start_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(got);
    check({tag, " resp_valid seen"}, got, 1);
    check({tag, " latency"}, cyc - t, v.lat);
    check({tag, " quot"}, resp_quot, v.quot);
    check({tag, " rem"}, resp_rem, v.rem);
    check({tag, " id"}, resp_id, v.id);
    check({tag, " dz"}, resp_dz, v.dz);
    check({tag, " start pulses"}, start_cnt - s0, v.starts);
    if (v.starts == 1) check({tag, " start cycle"}, last_start_cyc - t, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int t, ids_ok, gap;
    bit got, seen_ready;
    logic [31:0] q_hold, r_hold;

    vecs[0] = '{0, 32'd100,         32'd7,           32'd14,          32'd2,   35, 0, 1};
    vecs[1] = '{1, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0,   35, 0, 1};
`ifdef DIV_ARB_ZERO_BYPASS_EN
    vecs[2] = '{0, 32'd55,          32'd0,           32'hFFFF_FFFF,   32'd55,  1,  1, 0};
`else
    vecs[2] = '{0, 32'd55,          32'd0,           32'hFFFF_FFFF,   32'd55,  35, 0, 1};
`endif
    vecs[3] = '{1, 32'd7,           32'd100,         32'd0,           32'd7,   35, 0, 1};
    vecs[4] = '{0, 32'd12345678,    32'd1000,        32'd12345,       32'd678, 35, 0, 1};
    vecs[5] = '{1, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd1,           32'd0,   35, 0, 1};
    vecs[6] = '{0, 32'd0,           32'd5,           32'd0,           32'd0,   35, 0, 1};

    // Reset with both requesters asking: nothing may be accepted and all outputs sit at zero.
    req0_valid = 1'b1; req0_dividend = 32'd20; req0_divisor = 32'd4;
    req1_valid = 1'b1; req1_dividend = 32'd30; req1_divisor = 32'd6;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post-reset");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requesters valid continuously: grants alternate starting with requester 0.
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_dividend = 32'd100;  req0_divisor = 32'd7;
    req1_valid = 1'b1; req1_dividend = 32'd1000; req1_divisor = 32'd10;
    acc_cyc.delete();
    acc_id.delete();
    for (int k = 0; k < 4; k++) begin
      wait_resp(got);
      check($sformatf("rr resp%0d seen", k), got, 1);
      check($sformatf("rr resp%0d id", k), resp_id, k % 2);
      check($sformatf("rr resp%0d quot", k), resp_quot, (k % 2) ? 32'd100 : 32'd14);
      check($sformatf("rr resp%0d rem", k), resp_rem, (k % 2) ? 32'd0 : 32'd2);
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr acceptances", acc_cyc.size(), 4);
    ids_ok = 1;
    for (int k = 0; k < acc_cyc.size() && k < 4; k++) begin
      if (acc_id[k] != k[0]) ids_ok = 0;
      if (k > 0) begin
        gap = acc_cyc[k] - acc_cyc[k-1];
        check($sformatf("rr gap%0d", k), gap, 36);
      end
    end
    check("rr grant order", ids_ok, 1);

    // Back-pressure: result held stable and no acceptance while the consumer stalls.
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_dividend = 32'hFFFF_FFFF; req1_divisor = 32'd1;
    wait_accept(1, t, got);
    check("stall accepted", got, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(got);
    check("stall resp seen", got, 1);
    q_hold = resp_quot;
    r_hold = resp_rem;
    check("stall quot", q_hold, 32'hFFFF_FFFF);
    check("stall rem", r_hold, 32'd0);
    req0_valid = 1'b1; req0_dividend = 32'd8; req0_divisor = 32'd2;
    req1_valid = 1'b1; req1_dividend = 32'd9; req1_divisor = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d resp_valid", k), resp_valid, 1);
      check($sformatf("stall%0d quot", k), resp_quot, 32'hFFFF_FFFF);
      check($sformatf("stall%0d rem", k), resp_rem, 32'd0);
      check($sformatf("stall%0d id", k), resp_id, 1);
      check($sformatf("stall%0d readies", k), {req0_ready, req1_ready}, 2'b00);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall released", resp_valid, 0);

    // Reset in the middle of an operation restores requester 0 priority.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_dividend = 32'd100; req0_divisor = 32'd7;
    wait_accept(0, t, got);
    check("midrst accepted", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_dividend = 32'd50; req1_divisor = 32'd5;
    seen_ready = 1'b0;
    while (cyc < t + 10) begin
      @(negedge clk);
      if (req0_ready || req1_ready) seen_ready = 1'b1;
    end
    check("midrst busy readies", seen_ready, 0);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_dividend = 32'd9; req0_divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst priority", {req0_ready, req1_ready}, 2'b10);
    t = cyc;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(got);
    check("midrst resp seen", got, 1);
    check("midrst latency", cyc - t, 35);
    check("midrst quot", resp_quot, 32'd3);
    check("midrst rem", resp_rem, 32'd0);
    check("midrst id", resp_id, 0);
    @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
